ir_prefetch: RTL

Parametrised instruction register with a small prefetch queue.
- Memory pushes instruction words into a DEPTH-entry FIFO through a valid/ready handshake.
- The controller loads the head word into the IR with li.
- The IR is split into an opcode field (to the controller) and an operand field (gated onto the shared bus by ei).
- Sits between program memory and the control sequencer. flush discards prefetched words on a jump.

---
 rtl/ir_prefetch_pkg.sv | 12 +
 rtl/ir_prefetch_if.sv | 28 ++
 rtl/ir_fifo.sv | 69 ++++++
 rtl/ir_prefetch.sv | 67 ++++++
 4 files changed

// File: rtl/ir_prefetch_pkg.sv
// Shared defaults and helpers for the instruction register / prefetch queue.
package ir_prefetch_pkg;
   localparam int IW_DEF    = 8;
   localparam int OPW_DEF   = 4;
   localparam int DEPTH_DEF = 4;

   function automatic int opnd_w(input int iw, input int opw);
      return iw - opw;
   endfunction

   localparam logic [opnd_w(IW_DEF, OPW_DEF)-1:0] ZERO_OPND = '0;
endpackage

// File: rtl/ir_prefetch_if.sv
// Memory-side handshake plus controller/bus-side fields of the prefetching IR.
interface ir_prefetch_if
   import ir_prefetch_pkg::*;
#(
   parameter int IW    = IW_DEF,
   parameter int OPW   = OPW_DEF,
   parameter int DEPTH = DEPTH_DEF
) ();
   logic                      in_valid;
   logic [IW-1:0]             in_data;
   logic                      in_ready;
   logic                      li;
   logic                      ei;
   logic                      flush;
   logic [OPW-1:0]            ctrl;
   logic [IW-OPW-1:0]         bus;
   logic                      ir_valid;
   logic [$clog2(DEPTH):0]    count;

   modport master (
      output in_valid, in_data, li, ei, flush,
      input  in_ready, ctrl, bus, ir_valid, count
   );
   modport slave (
      input  in_valid, in_data, li, ei, flush,
      output in_ready, ctrl, bus, ir_valid, count
   );
endinterface

// File: rtl/ir_fifo.sv
// Prefetch FIFO: power-of-two storage with free-running wrapping pointers and an exact count.
module ir_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rp_q];
   assign count   = cnt_q;

   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (flush) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wp_q] = wdata;
            wp_d        = wp_q + AW'(1);
         end
         if (do_pop) rp_d = rp_q + AW'(1);
         // Push and pop together leave the count alone.
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         mem_q <= '{default: '0};
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/ir_prefetch.sv
// Instruction register fed from a prefetch FIFO; opcode goes to the sequencer,
// operand is gated onto the shared bus.
module ir_prefetch
   import ir_prefetch_pkg::*;
#(
   parameter int IW    = IW_DEF,
   parameter int OPW   = OPW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic         clk,
   input  logic         clr,
   ir_prefetch_if.slave pf
);
   localparam int OW = opnd_w(IW, OPW);

   logic                   push, pop, full, empty;
   logic [IW-1:0]          head;
   logic [IW-1:0]          ir_q, ir_d;
   logic                   irv_q, irv_d;
   logic [$clog2(DEPTH):0] cnt;

   // Ready ignores li on purpose: no push-into-pop slot when full.
   assign pf.in_ready = !full && !pf.flush;
   assign push        = pf.in_valid && pf.in_ready;
   assign pop         = pf.li && !empty && !pf.flush;

   ir_fifo #(.WIDTH(IW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .flush (pf.flush),
      .wdata (pf.in_data),
      .rdata (head),
      .count (cnt),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      ir_d  = ir_q;
      irv_d = irv_q;
      if (pf.flush) begin
         ir_d  = '0;
         irv_d = 1'b0;
      end else if (pf.li) begin
         // Loading from an empty queue yields a bubble rather than bypassing in_data.
         ir_d  = empty ? '0 : head;
         irv_d = !empty;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         ir_q  <= '0;
         irv_q <= 1'b0;
      end else begin
         ir_q  <= ir_d;
         irv_q <= irv_d;
      end
   end

   assign pf.ctrl     = ir_q[IW-1 -: OPW];
   assign pf.bus      = pf.ei ? ir_q[OW-1:0] : OW'(ZERO_OPND);
   assign pf.ir_valid = irv_q;
   assign pf.count    = cnt;
endmodule
